// File: rtl/mag_pkg.sv
// Shared types and elaboration-time helpers for the iterative magnitude unit.
package mag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  function automatic int ceil_div2(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/mag_sqrt_iter_step.sv
// One restoring square-root digit: folds two radicand bits into the partial
// remainder and decides the next root bit.
module sqrt_step #(
  parameter int R_W = 9
) (
  input  logic [R_W+1:0] rem_i,
  input  logic [R_W-1:0] root_i,
  input  logic [1:0]     bits_i,
  output logic [R_W+1:0] rem_o,
  output logic [R_W-1:0] root_o
);

  logic [R_W+3:0] shifted;
  logic [R_W+3:0] trial;
  logic [R_W+3:0] diff;
  logic           ge;
  logic           unused;

  always_comb begin
    shifted = {rem_i, bits_i};
    trial   = {2'b00, root_i, 2'b01};
    ge      = (shifted >= trial);
    diff    = shifted - trial;
    // Remainder never exceeds 2*root, so the top two bits are always zero.
    rem_o   = ge ? diff[R_W+1:0] : shifted[R_W+1:0];
    root_o  = {root_i[R_W-2:0], ge};
  end

  assign unused = ^{diff[R_W+3:R_W+2], shifted[R_W+3:R_W+2], root_i[R_W-1]};

endmodule

// File: rtl/mag_sqrt_iter.sv
// Handshaked magnitude unit: sqrt(sqrx + sqry), one root bit per clock,
// optional round-to-nearest on the final result.
module mag_sqrt_iter
  import mag_pkg::*;
#(
  parameter int SQ_W  = 17,
  parameter int OUT_W = 11,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SQ_W-1:0]  sqrx,
  input  logic [SQ_W-1:0]  sqry,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] magnitude,
  output logic             exact,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SUM_W = SQ_W + 1;
  localparam int R_W   = ceil_div2(SUM_W);
  localparam int RAD_W = 2 * R_W;
  localparam int REM_W = R_W + 2;
  localparam int CNT_W = (clog2(R_W) < 1) ? 1 : clog2(R_W);

  if (OUT_W < R_W + ROUND) begin : g_out_w_chk
    $error("mag_sqrt_iter: OUT_W must be at least R_W + ROUND");
  end

  state_e             state_q, state_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [R_W-1:0]     root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   mag_q, mag_d;
  logic               exact_q, exact_d;

  logic [SUM_W-1:0]   sum;
  logic [RAD_W-1:0]   rad_ld;
  logic [REM_W-1:0]   step_rem;
  logic [R_W-1:0]     step_root;
  logic [OUT_W-1:0]   root_ext;
  logic               rnd_up;
  logic               ld;

  sqrt_step #(.R_W(R_W)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RAD_W-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_comb begin
    sum                = SUM_W'(sqrx) + SUM_W'(sqry);
    rad_ld             = '0;
    rad_ld[SUM_W-1:0]  = sum;
    root_ext           = '0;
    root_ext[R_W-1:0]  = step_root;
    rnd_up             = (ROUND != 0) && (step_rem > REM_W'(step_root));
  end

  assign ld        = in_valid && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid = !rst && (state_q == DONE);
  assign magnitude = mag_q;
  assign exact     = exact_q;

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    exact_d = exact_q;
    case (state_q)
      IDLE: ;
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = step_rem;
        root_d = step_root;
        if (cnt_q == '0) begin
          state_d = DONE;
          mag_d   = root_ext + OUT_W'(rnd_up);
          exact_d = (step_rem == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A load from DONE overrides the return to IDLE, giving back-to-back issue.
    if (ld) begin
      state_d = CALC;
      rad_d   = rad_ld;
      rem_d   = '0;
      root_d  = '0;
      cnt_d   = CNT_W'(R_W - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      mag_q   <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      exact_q <= exact_d;
    end
  end

endmodule

// File: tb/tb_mag_sqrt_iter.sv
// Bench for mag_sqrt_iter: floor and round instances share one stimulus
// stream; a queue-based reference model checks every valid output cycle.
module tb_mag_sqrt_iter;

  localparam int SQ_W  = 17;
  localparam int OUT_W = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SQ_W-1:0]  sqrx = '0;
  logic [SQ_W-1:0]  sqry = '0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready0, in_ready1, out_valid0, out_valid1, exact0, exact1;
  logic [OUT_W-1:0] mag0, mag1;

  mag_sqrt_iter #(.SQ_W(SQ_W), .OUT_W(OUT_W), .ROUND(0)) u_floor (
    .clk(clk), .rst(rst), .sqrx(sqrx), .sqry(sqry), .in_valid(in_valid),
    .in_ready(in_ready0), .magnitude(mag0), .exact(exact0),
    .out_valid(out_valid0), .out_ready(out_ready));

  mag_sqrt_iter #(.SQ_W(SQ_W), .OUT_W(OUT_W), .ROUND(1)) u_round (
    .clk(clk), .rst(rst), .sqrx(sqrx), .sqry(sqry), .in_valid(in_valid),
    .in_ready(in_ready1), .magnitude(mag1), .exact(exact1),
    .out_valid(out_valid1), .out_ready(out_ready));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nfail = 0;
  int npop = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: largest r with r*r <= n, by trial squaring.
  function automatic longint isqrt(input longint n);
    longint r;
    longint c;
    r = 0;
    for (int b = 10; b >= 0; b--) begin
      c = r | (longint'(1) << b);
      if (c * c <= n) r = c;
    end
    return r;
  endfunction

  // Nearest integer to sqrt(n): round up iff n > r^2 + r.
  function automatic longint rsqrt(input longint n);
    longint r;
    r = isqrt(n);
    return (n > r * r + r) ? r + 1 : r;
  endfunction

  typedef struct {
    longint m0;
    longint m1;
    longint ex;
    int     c;
  } exp_t;

  exp_t q[$];
  bit   first_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      first_seen = 1'b0;
    end else begin
      if (out_valid0 || out_valid1) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          if (!first_seen) chk("latency", cyc - q[0].c, 10);
          chk("out_valid_floor", longint'(out_valid0), 1);
          chk("out_valid_round", longint'(out_valid1), 1);
          chk("mag_floor", longint'(mag0), q[0].m0);
          chk("mag_round", longint'(mag1), q[0].m1);
          chk("exact_floor", longint'(exact0), q[0].ex);
          chk("exact_round", longint'(exact1), q[0].ex);
          if (out_ready) begin
            void'(q.pop_front());
            npop++;
            first_seen = 1'b0;
          end else begin
            first_seen = 1'b1;
          end
        end
      end
      if (in_valid && in_ready0) begin
        longint n;
        n = longint'(sqrx) + longint'(sqry);
        q.push_back('{m0: isqrt(n), m1: rsqrt(n),
                      ex: (isqrt(n) * isqrt(n) == n) ? 1 : 0, c: cyc});
      end
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid0) chk("wait_out_valid_timeout", 0, 1);
  endtask

  task automatic op(input int x, input int y, input int e0, input int e1, input int ex);
    int acc;
    @(posedge clk); #1;
    sqrx = SQ_W'(x); sqry = SQ_W'(y); in_valid = 1'b1; out_ready = 1'b0;
    acc = cyc;
    #1 chk("op_in_ready", longint'(in_ready0), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    chk("op_latency", cyc - acc, 10);
    chk("op_mag_floor", longint'(mag0), e0);
    chk("op_mag_round", longint'(mag1), e1);
    chk("op_exact", longint'(exact0), ex);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int nv;
    int sent;
    bit hs;

    chk("model_isqrt_25", isqrt(25), 5);
    chk("model_isqrt_262142", isqrt(262142), 511);
    chk("model_rsqrt_262142", rsqrt(262142), 512);
    chk("model_rsqrt_7", rsqrt(7), 3);
    chk("model_rsqrt_6", rsqrt(6), 2);

    // Reset state
    repeat (3) begin
      @(posedge clk); #1;
      chk("in_ready_during_rst", longint'(in_ready0), 0);
    end
    rst = 1'b0;
    #1;
    chk("rst_in_ready", longint'(in_ready0), 1);
    chk("rst_out_valid", longint'(out_valid0), 0);
    chk("rst_mag", longint'(mag0), 0);
    chk("rst_exact", longint'(exact0), 0);

    // Directed vectors: sqrx, sqry, floor, round, exact
    op(9, 16, 5, 5, 1);
    op(131071, 131071, 511, 512, 0);
    op(3, 4, 2, 3, 0);
    op(6, 0, 2, 2, 0);
    op(0, 0, 0, 0, 1);

    // Stall in DONE, then back-to-back accept
    @(posedge clk); #1;
    sqrx = 1; sqry = 3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("stall_mag", longint'(mag0), 2);
      chk("stall_exact", longint'(exact0), 1);
      chk("stall_in_ready", longint'(in_ready0), 0);
      chk("stall_out_valid", longint'(out_valid0), 1);
      @(posedge clk); #1;
    end
    sqrx = 50; sqry = 50; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", longint'(in_ready0), 1);
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    wait_valid();
    chk("b2b_latency", cyc - acc, 10);
    chk("b2b_mag", longint'(mag0), 10);
    chk("b2b_exact", longint'(exact0), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the fourth CALC cycle aborts the operation
    @(posedge clk); #1;
    sqrx = 100; sqry = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_in_ready", longint'(in_ready0), 1);
    out_ready = 1'b1;
    nv = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) nv++;
    end
    chk("abort_no_out_valid", nv, 0);
    out_ready = 1'b0;
    op(100, 0, 10, 10, 1);

    // Randomised traffic with random valid/ready
    npop = 0;
    sent = 0;
    hs = 1'b0;
    for (int c = 0; c < 40000 && sent < 1500; c++) begin
      @(posedge clk); #1;
      if (hs) in_valid = 1'b0;
      if (!in_valid && ($urandom % 2 == 0)) begin
        case ($urandom % 4)
          0: begin sqrx = SQ_W'($urandom); sqry = SQ_W'($urandom); end
          1: begin sqrx = SQ_W'($urandom % 64); sqry = SQ_W'($urandom % 64); end
          2: begin sqrx = SQ_W'(131071 - $urandom % 8); sqry = SQ_W'(131071 - $urandom % 8); end
          default: begin
            sqrx = SQ_W'(($urandom % 362) * ($urandom % 362));
            sqry = '0;
          end
        endcase
        in_valid = 1'b1;
      end
      out_ready = ($urandom % 4) != 0;
      #1;
      hs = in_valid && in_ready0;
      if (hs) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rand_sent", sent, 1500);
    chk("rand_results", npop, sent);
    chk("rand_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
